// File: rtl/iob_ila_dump_pkg.sv
// Shared types and sizing helpers for the ILA buffer readout engine.
package iob_ila_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SAMP,
    S_WR_IDX,
    S_WR_SEL,
    S_RD_DATA,
    S_PUSH,
    S_FIN
  } state_t;

  function automatic int words_f(input int signal_w, input int data_w);
    int w;
    w = (signal_w + data_w - 1) / data_w;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int sel_w_f(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int DEF_SIGNAL_W = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int WORDS        = words_f(DEF_SIGNAL_W, DEF_DATA_W);
  localparam int SEL_W        = sel_w_f(WORDS);

endpackage

// File: rtl/iob_ila_dump.sv
// Bus-master readout of the iob_ila capture buffer: reads SAMPLES, then walks
// INDEX/SIGNAL_SELECT/DATA for every word and pushes it out on a stream.
module iob_ila_dump
  import iob_ila_dump_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 32,
  parameter int                SIGNAL_W     = 32,
  parameter int                BUFFER_W     = 10,
  parameter logic [ADDR_W-1:0] SAMPLES_ADDR = '0,
  parameter logic [ADDR_W-1:0] INDEX_ADDR   = '0,
  parameter logic [ADDR_W-1:0] SELECT_ADDR  = '0,
  parameter logic [ADDR_W-1:0] DATA_ADDR    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [BUFFER_W:0]     count,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     s_tdata,
  output logic                  s_tvalid,
  input  logic                  s_tready,
  output logic                  s_tlast
);

  localparam int                L_WORDS = words_f(SIGNAL_W, DATA_W);
  localparam int                L_SEL_W = sel_w_f(L_WORDS);
  localparam int                CNT_W   = BUFFER_W + 1;
  localparam logic [CNT_W-1:0]  MAX_CNT = {1'b1, {BUFFER_W{1'b0}}};

  state_t               r_state, w_next;
  logic [BUFFER_W-1:0]  r_idx;
  logic [L_SEL_W-1:0]   r_sel;
  logic [CNT_W-1:0]     r_count;
  logic [DATA_W-1:0]    r_tdata;
  logic                 r_abort;

  logic [CNT_W-1:0]     w_rd_cnt;
  logic                 w_abort;
  logic                 w_last_idx;
  logic                 w_last_sel;

  // Anything at or above 2**BUFFER_W saturates, including huge upper-bit values.
  assign w_rd_cnt   = (|m_rdata[DATA_W-1:BUFFER_W]) ? MAX_CNT : {1'b0, m_rdata[BUFFER_W-1:0]};
  assign w_abort    = r_abort | abort;
  assign w_last_idx = ({1'b0, r_idx} == (r_count - CNT_W'(1)));
  assign w_last_sel = (r_sel == L_SEL_W'(L_WORDS - 1));

  assign count   = r_count;
  assign s_tdata = r_tdata;
  assign s_tlast = (r_state == S_PUSH) && w_last_idx && w_last_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE || r_state == S_FIN) r_abort <= 1'b0;
      else if (abort)                            r_abort <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_sel   <= '0;
      r_count <= '0;
      r_tdata <= '0;
    end else begin
      case (r_state)
        S_RD_SAMP: if (m_ready) begin
          r_count <= w_rd_cnt;
          r_idx   <= '0;
        end
        S_WR_IDX:  if (m_ready) r_sel <= '0;
        S_RD_DATA: if (m_ready) r_tdata <= m_rdata;
        S_PUSH: if (s_tready) begin
          if (!w_last_sel)      r_sel <= r_sel + 1'b1;
          else if (!w_last_idx) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    m_valid  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    busy     = 1'b1;
    done     = 1'b0;
    s_tvalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_RD_SAMP;
      end
      S_RD_SAMP: begin
        m_valid = 1'b1;
        m_addr  = SAMPLES_ADDR;
        if (m_ready) w_next = (w_rd_cnt == '0 || w_abort) ? S_FIN : S_WR_IDX;
      end
      S_WR_IDX: begin
        m_valid = 1'b1;
        m_addr  = INDEX_ADDR;
        m_wdata = DATA_W'(r_idx);
        m_wstrb = '1;
        if (m_ready) w_next = w_abort ? S_FIN : S_WR_SEL;
      end
      S_WR_SEL: begin
        m_valid = 1'b1;
        m_addr  = SELECT_ADDR;
        m_wdata = DATA_W'(r_sel);
        m_wstrb = '1;
        if (m_ready) w_next = w_abort ? S_FIN : S_RD_DATA;
      end
      S_RD_DATA: begin
        // The word being read is always delivered, even under abort.
        m_valid = 1'b1;
        m_addr  = DATA_ADDR;
        if (m_ready) w_next = S_PUSH;
      end
      S_PUSH: begin
        s_tvalid = 1'b1;
        if (s_tready) begin
          if (w_abort || (w_last_idx && w_last_sel)) w_next = S_FIN;
          else if (!w_last_sel)                      w_next = S_WR_SEL;
          else                                       w_next = S_WR_IDX;
        end
      end
      S_FIN: begin
        busy   = 1'b0;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_ila_dump.sv
// Bench for iob_ila_dump: two instances (one and two words per sample) against
// an ILA slave model, with expected bus/stream sequences built from the dump rules.
module tb_iob_ila_dump;

  localparam int          BW     = 3;
  localparam int          MAXS   = 1 << BW;
  localparam logic [15:0] A_SAMP = 16'h0000;
  localparam logic [15:0] A_IDX  = 16'h0004;
  localparam logic [15:0] A_SEL  = 16'h0008;
  localparam logic [15:0] A_DATA = 16'h000C;

  typedef struct packed { logic [15:0] addr; logic we; logic [31:0] wdata; } bus_t;
  typedef struct packed { logic [31:0] data; logic last; } str_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] abort_i, m_ready, s_tready;
  logic [1:0][31:0] m_rdata;

  wire [1:0]        busy, done, m_valid, s_tvalid, s_tlast;
  wire [1:0][BW:0]  count;
  wire [1:0][15:0]  m_addr;
  wire [1:0][31:0]  m_wdata, s_tdata;
  wire [1:0][3:0]   m_wstrb;

  logic [31:0] cfg_samples [2];
  int cfg_wmax [2], cfg_mode [2], cfg_abort [2], cfg_busy [2], cfg_nw [2];
  int rst_evt = 0;

  int checks = 0, errors = 0;
  bus_t eb [2][$];
  str_t es [2][$];
  logic [31:0] sl_idx [2], sl_sel [2], p_wdata [2], p_tdata [2];
  logic [15:0] p_addr [2];
  logic [3:0]  p_wstrb [2];
  logic        p_tlast [2];
  bit pend_m [2], pend_s [2], active [2], fired [2];
  int wait_left [2], busy_cyc [2], fin_cnt [2], words_got [2], exp_count [2];
  int seen_evt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    iob_ila_dump #(
      .ADDR_W(16), .DATA_W(32), .SIGNAL_W(g == 0 ? 32 : 40), .BUFFER_W(BW),
      .SAMPLES_ADDR(A_SAMP), .INDEX_ADDR(A_IDX), .SELECT_ADDR(A_SEL), .DATA_ADDR(A_DATA)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .abort(abort_i[g]),
      .busy(busy[g]), .done(done[g]), .count(count[g]),
      .m_valid(m_valid[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]), .m_wstrb(m_wstrb[g]),
      .m_rdata(m_rdata[g]), .m_ready(m_ready[g]),
      .s_tdata(s_tdata[g]), .s_tvalid(s_tvalid[g]), .s_tready(s_tready[g]), .s_tlast(s_tlast[g])
    );
  end

  function automatic int words_of(input int g);
    return ((g == 0 ? 32 : 40) + 31) / 32;
  endfunction

  function automatic logic [31:0] data_f(input int g, input logic [31:0] idx, input logic [31:0] sel);
    logic [7:0] tag;
    tag = 8'hD0 + 8'(g);
    return {tag, sel[7:0], idx[15:0]};
  endfunction

  task automatic chk(input bit ok, input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s (inst %0d): actual %h, required %h", nm, g, act, exp);
    end
  endtask

  task automatic clear_model(input int g);
    eb[g].delete();
    es[g].delete();
    pend_m[g] = 0; pend_s[g] = 0; active[g] = 0; fired[g] = 0;
    m_ready[g] = 1'b0; s_tready[g] = 1'b0; abort_i[g] = 1'b0; m_rdata[g] = '0;
  endtask

  task automatic build_model(input int g);
    int c, n, wd;
    wd = words_of(g);
    c  = (cfg_samples[g] > 32'(MAXS)) ? MAXS : int'(cfg_samples[g]);
    n  = (cfg_abort[g] >= 0 && cfg_abort[g] < c) ? cfg_abort[g] + 1 : c;
    exp_count[g] = c;
    eb[g].delete();
    es[g].delete();
    eb[g].push_back('{A_SAMP, 1'b0, 32'h0});
    for (int i = 0; i < n; i++) begin
      eb[g].push_back('{A_IDX, 1'b1, 32'(i)});
      for (int s = 0; s < wd; s++) begin
        eb[g].push_back('{A_SEL, 1'b1, 32'(s)});
        eb[g].push_back('{A_DATA, 1'b0, 32'h0});
        es[g].push_back('{data_f(g, 32'(i), 32'(s)), (i == c - 1) && (s == wd - 1)});
      end
    end
    active[g] = 1; fired[g] = 0; busy_cyc[g] = 0; words_got[g] = 0;
  endtask

  always @(negedge clk) begin
    bus_t t;
    str_t e;
    bit   tr;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        chk({busy[g], done[g], m_valid[g], s_tvalid[g], s_tlast[g], count[g], m_addr[g], m_wstrb[g]} == '0
            && m_wdata[g] == '0 && s_tdata[g] == '0, g, "reset_outputs",
            {busy[g], done[g], m_valid[g], s_tvalid[g], m_addr[g], s_tdata[g]}, 64'h0);
        clear_model(g);
      end else begin
        if (seen_evt != rst_evt) begin
          chk(!s_tvalid[g] && !busy[g] && !done[g] && !m_valid[g], g, "async_reset",
              {s_tvalid[g], busy[g], done[g], m_valid[g]}, 64'h0);
          clear_model(g);
        end
        abort_i[g] = 1'b0;
        if (pend_m[g])
          chk(m_valid[g] && m_addr[g] == p_addr[g] && m_wdata[g] == p_wdata[g] && m_wstrb[g] == p_wstrb[g],
              g, "bus_hold", {m_valid[g], m_addr[g], m_wdata[g]}, {1'b1, p_addr[g], p_wdata[g]});
        if (pend_s[g])
          chk(s_tvalid[g] && s_tdata[g] == p_tdata[g] && s_tlast[g] == p_tlast[g],
              g, "stream_hold", {s_tvalid[g], s_tlast[g], s_tdata[g]}, {1'b1, p_tlast[g], p_tdata[g]});
        if (!active[g]) begin
          chk(!m_valid[g] && !s_tvalid[g] && !done[g] && !busy[g], g, "idle_quiet",
              {m_valid[g], s_tvalid[g], done[g], busy[g]}, 64'h0);
          if (start[g]) build_model(g);
        end
        if (cfg_abort[g] >= 0 && active[g] && !fired[g] && m_valid[g] && m_wstrb[g] == 4'h0
            && m_addr[g] == A_DATA && sl_idx[g] == 32'(cfg_abort[g])) begin
          abort_i[g] = 1'b1;
          fired[g]   = 1;
        end
        m_ready[g] = 1'b0;
        if (m_valid[g]) begin
          if (!pend_m[g]) begin
            wait_left[g] = $urandom_range(0, cfg_wmax[g]);
            p_addr[g] = m_addr[g]; p_wdata[g] = m_wdata[g]; p_wstrb[g] = m_wstrb[g];
            pend_m[g] = 1;
          end
          if (wait_left[g] == 0) begin
            m_ready[g] = 1'b1;
            pend_m[g]  = 0;
            if (eb[g].size() == 0) chk(0, g, "bus_extra", {m_addr[g], m_wstrb[g]}, 64'h0);
            else begin
              t = eb[g].pop_front();
              chk(m_addr[g] == t.addr && m_wstrb[g] == (t.we ? 4'hF : 4'h0) && (!t.we || m_wdata[g] == t.wdata),
                  g, "bus_xfer", {m_addr[g], m_wstrb[g], m_wdata[g]}, {t.addr, (t.we ? 4'hF : 4'h0), t.wdata});
            end
            if (m_wstrb[g] != 4'h0) begin
              if (m_addr[g] == A_IDX) sl_idx[g] = m_wdata[g];
              if (m_addr[g] == A_SEL) sl_sel[g] = m_wdata[g];
            end
            m_rdata[g] = (m_addr[g] == A_SAMP) ? cfg_samples[g] :
                         (m_addr[g] == A_DATA) ? data_f(g, sl_idx[g], sl_sel[g]) : 32'hDEAD_BEEF;
          end else begin
            wait_left[g]--;
            m_rdata[g] = 32'h0BAD_0BAD;
          end
        end
        s_tready[g] = 1'b0;
        if (s_tvalid[g]) begin
          if (!pend_s[g]) begin
            p_tdata[g] = s_tdata[g]; p_tlast[g] = s_tlast[g]; pend_s[g] = 1;
          end
          tr = (cfg_mode[g] == 0) ? 1'b1 : (cfg_mode[g] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          s_tready[g] = tr;
          if (tr) begin
            pend_s[g] = 0;
            words_got[g]++;
            if (es[g].size() == 0) chk(0, g, "stream_extra", {s_tlast[g], s_tdata[g]}, 64'h0);
            else begin
              e = es[g].pop_front();
              chk(s_tdata[g] == e.data && s_tlast[g] == e.last, g, "stream_word",
                  {s_tlast[g], s_tdata[g]}, {e.last, e.data});
            end
          end
        end
        if (busy[g]) busy_cyc[g]++;
        if (done[g]) begin
          chk(active[g] && !busy[g], g, "done_busy", {active[g], busy[g]}, 64'h2);
          chk(64'(count[g]) == 64'(exp_count[g]), g, "count", 64'(count[g]), 64'(exp_count[g]));
          chk(eb[g].size() == 0, g, "bus_left", 64'(eb[g].size()), 64'h0);
          chk(es[g].size() == 0, g, "words_left", 64'(es[g].size()), 64'h0);
          if (cfg_busy[g] >= 0) chk(busy_cyc[g] == cfg_busy[g], g, "busy_cycles", 64'(busy_cyc[g]), 64'(cfg_busy[g]));
          if (cfg_nw[g] >= 0) chk(words_got[g] == cfg_nw[g], g, "word_total", 64'(words_got[g]), 64'(cfg_nw[g]));
          active[g] = 0;
          fin_cnt[g]++;
        end
      end
    end
    seen_evt = rst_evt;
  end

  task automatic run(input int g, input logic [31:0] samp, input int wmax, input int mode,
                     input int ab, input int expb, input int nw);
    int f0, n;
    cfg_samples[g] = samp; cfg_wmax[g] = wmax; cfg_mode[g] = mode;
    cfg_abort[g] = ab; cfg_busy[g] = expb; cfg_nw[g] = nw;
    f0 = fin_cnt[g];
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
    n = 0;
    while (fin_cnt[g] == f0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (fin_cnt[g] == f0) begin
      $display("FAIL dump_timeout (inst %0d): no done after %0d cycles", g, n);
      $fatal(1, "dump did not finish");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int g = 0; g < 2; g++) begin
      cfg_samples[g] = 0; cfg_wmax[g] = 0; cfg_mode[g] = 0;
      cfg_abort[g] = -1; cfg_busy[g] = -1; cfg_nw[g] = -1;
      fin_cnt[g] = 0; sl_idx[g] = 0; sl_sel[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run(0, 32'd0, 0, 0, -1, 1, 0);
    run(0, 32'd3, 0, 0, -1, 13, 3);
    run(1, 32'd2, 0, 0, -1, 15, 4);
    run(0, 32'h8000_0003, 0, 0, -1, 33, 8);
    run(1, 32'd1, 0, 0, -1, 8, 2);
    run(1, 32'd5, 3, 1, -1, -1, 10);
    run(0, 32'd4, 3, 1, -1, -1, 4);
    run(0, 32'd3, 1, 0, 1, -1, 2);

    // Reset pulse placed between clock edges while a word is stalled in the stream.
    cfg_samples[0] = 3; cfg_wmax[0] = 0; cfg_mode[0] = 2; cfg_abort[0] = -1; cfg_busy[0] = -1; cfg_nw[0] = -1;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    n = 0;
    while (!s_tvalid[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tvalid[0]) begin
      $display("FAIL push_timeout (inst 0): tvalid never seen");
      $fatal(1, "no stream word");
    end
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    rst_evt++;
    repeat (5) @(negedge clk);
    run(0, 32'd3, 0, 0, -1, 13, 3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
